// File: rtl/keypad_scanner_pkg.sv
// Shared constants and types for the 4x4 hex keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned KEYS   = ROWS * COLS;
  localparam int unsigned CODE_W = 4;

  localparam logic [ROWS-1:0] ROW_RST = 4'b1110;

  // Index r*4+c; element 0 is row 0 / column 0.
  localparam logic [KEYS-1:0][CODE_W-1:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  typedef enum logic {
    ARMED    = 1'b0,
    REPORTED = 1'b1
  } scan_state_e;

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchroniser for asynchronous level inputs.
module sync2 #(
  parameter int unsigned     WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row ring, debounced full-scan snapshots,
// single-report FSM and a shifting 8-digit entry register.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CNT_END   = 199_999,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  input  logic        value_clr,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] value
);

  localparam int unsigned CNT_W = $clog2(SCAN_CNT_END + 1);
  localparam int unsigned STB_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_row;
  logic [KEYS-1:0]   r_cur_snap;
  logic [KEYS-1:0]   r_prev_snap;
  logic [STB_W-1:0]  r_stable;
  scan_state_e       r_state;

  logic [COLS-1:0]   w_col_sync;
  logic              w_slot_end;
  logic              w_scan_end;
  logic [KEYS-1:0]   w_snap;
  logic [STB_W-1:0]  w_stable_nxt;
  logic              w_stable_full;
  logic              w_one_hot;
  logic [3:0]        w_key_idx;

  sync2 #(.WIDTH(COLS), .RST_VAL('1)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .i_d (col_in),
    .o_q (w_col_sync)
  );

  // The ring visits physical rows 0,3,2,1; the row-1 slot is the last of a scan.
  assign w_slot_end = (r_cnt == CNT_W'(SCAN_CNT_END));
  assign w_scan_end = w_slot_end && (r_row == 2'd1);

  always_comb begin
    w_snap = r_cur_snap;
    w_snap[{r_row, 2'b00} +: COLS] = ~w_col_sync;

    if (w_snap == r_prev_snap) begin
      w_stable_nxt = (r_stable == STB_W'(DEBOUNCE_SCANS)) ? r_stable : r_stable + 1'b1;
    end else begin
      w_stable_nxt = STB_W'(1);
    end
    w_stable_full = (w_stable_nxt == STB_W'(DEBOUNCE_SCANS));

    w_key_idx = '0;
    for (int i = 0; i < int'(KEYS); i++) begin
      if (w_snap[i]) w_key_idx = 4'(i);
    end
    w_one_hot = (w_snap != '0) && ((w_snap & (w_snap - 16'd1)) == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_row       <= 2'd0;
      row_out     <= ROW_RST;
      r_cur_snap  <= '0;
      r_prev_snap <= '0;
      r_stable    <= '0;
      r_state     <= ARMED;
      key_valid   <= 1'b0;
      key_code    <= '0;
    end else begin
      key_valid <= 1'b0;

      if (w_slot_end) begin
        r_cnt      <= '0;
        row_out    <= {row_out[0], row_out[3:1]};
        r_row      <= r_row - 2'd1;
        r_cur_snap <= w_snap;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_scan_end) begin
        r_prev_snap <= w_snap;
        r_stable    <= w_stable_nxt;
        case (r_state)
          ARMED: begin
            if (w_stable_full && w_one_hot) begin
              key_valid <= 1'b1;
              key_code  <= KEY_MAP[w_key_idx];
              r_state   <= REPORTED;
            end
          end
          REPORTED: begin
            if (w_stable_full && (w_snap == '0)) r_state <= ARMED;
          end
          default: r_state <= ARMED;
        endcase
      end
    end
  end

  // Clear wins over history but still keeps a digit accepted in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (value_clr && key_valid) begin
      value <= {28'h0, key_code};
    end else if (value_clr) begin
      value <= '0;
    end else if (key_valid) begin
      value <= {value[27:0], key_code};
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with 4-clk slots and 2-scan debounce.
module tb_keypad_scanner;

  logic        clk;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic        value_clr;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] value;

  logic [15:0] keys_down;
  int          total = 0;
  int          bad   = 0;
  int          pulses = 0;
  int          p0;
  bit          seen;
  int          digit_idx [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  keypad_scanner #(.SCAN_CNT_END(3), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .row_out   (row_out),
    .col_in    (col_in),
    .value_clr (value_clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_out[r] && keys_down[r*4+c]) col_in[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (key_valid === 1'b1) pulses <= pulses + 1;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_pulse(input int max_clks, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_clks && !got; i++) begin
      step(1);
      if (key_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic press_one(input int idx);
    keys_down      = '0;
    keys_down[idx] = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    value_clr = 1'b0;
    keys_down = '0;

    // Reset state and row ring timing
    step(3);
    check("rst_row", row_out, 4'b1110);
    check("rst_kv", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_value", value, 32'h0);
    #2 rst = 1'b0;
    step(6);
    check("ring_pre", row_out, 4'b0111);
    #2 rst = 1'b1;
    #1 check("async_row", row_out, 4'b1110);
    check("async_value", value, 32'h0);
    step(2);
    #2 rst = 1'b0;
    step(3);
    check("ring_hold", row_out, 4'b1110);
    step(1);
    check("ring_rot1", row_out, 4'b0111);
    step(4);
    check("ring_rot2", row_out, 4'b1011);

    // Single press of key 8, then long hold
    p0 = pulses;
    press_one(9);
    wait_pulse(80, seen);
    check("k8_seen", 32'(seen), 32'd1);
    check("k8_code", key_code, 4'h8);
    step(1);
    check("k8_one_clk", key_valid, 1'b0);
    check("k8_value", value, 32'h0000_0008);
    step(160);
    check("k8_hold_pulses", pulses - p0, 32'd1);
    keys_down = '0;
    step(48);

    // Bounce on key 5 for 6 scans, then steady
    p0 = pulses;
    repeat (3) begin
      press_one(5);
      step(16);
      keys_down = '0;
      step(16);
    end
    check("bounce_quiet", pulses - p0, 32'd0);
    press_one(5);
    wait_pulse(52, seen);
    check("k5_seen", 32'(seen), 32'd1);
    check("k5_code", key_code, 4'h5);
    keys_down = '0;
    step(48);
    check("k5_pulses", pulses - p0, 32'd1);

    // Roll-over: key 1 then key 2 added
    p0 = pulses;
    press_one(0);
    wait_pulse(52, seen);
    check("k1_seen", 32'(seen), 32'd1);
    check("k1_code", key_code, 4'h1);
    keys_down[1] = 1'b1;
    step(64);
    check("rollover_pulses", pulses - p0, 32'd1);
    check("rollover_code", key_code, 4'h1);
    keys_down = '0;
    step(48);
    press_one(1);
    wait_pulse(52, seen);
    check("k2_seen", 32'(seen), 32'd1);
    check("k2_code", key_code, 4'h2);
    keys_down = '0;
    step(48);
    check("value_8512", value, 32'h0000_8512);

    // Two keys together from armed
    p0 = pulses;
    keys_down = 16'h0003;
    step(96);
    check("dual_quiet", pulses - p0, 32'd0);
    keys_down = '0;
    step(48);

    // Entry and wrap
    value_clr = 1'b1;
    step(1);
    value_clr = 1'b0;
    check("clr_value", value, 32'h0);
    p0 = pulses;
    for (int d = 0; d < 9; d++) begin
      press_one(digit_idx[d]);
      wait_pulse(52, seen);
      keys_down = '0;
      step(48);
    end
    check("entry_pulses", pulses - p0, 32'd9);
    check("entry_wrap", value, 32'h2345_6789);
    value_clr = 1'b1;
    step(1);
    value_clr = 1'b0;
    check("clr_again", value, 32'h0);
    press_one(0);
    wait_pulse(52, seen);
    keys_down = '0;
    step(48);
    check("value_1", value, 32'h0000_0001);
    press_one(14);
    wait_pulse(52, seen);
    check("kf_seen", 32'(seen), 32'd1);
    value_clr = 1'b1;
    step(1);
    value_clr = 1'b0;
    check("kf_code", key_code, 4'hF);
    check("clr_with_key", value, 32'h0000_000F);
    keys_down = '0;
    step(48);

    // Reset while holding key A
    press_one(3);
    step(16);
    #2 rst = 1'b1;
    #1 check("midhold_code", key_code, 4'h0);
    check("midhold_value", value, 32'h0);
    step(2);
    #2 rst = 1'b0;
    p0 = pulses;
    step(31);
    check("ka_early", key_valid, 1'b0);
    step(1);
    check("ka_pulse", key_valid, 1'b1);
    check("ka_code", key_code, 4'hA);
    step(160);
    check("ka_once", pulses - p0, 32'd1);
    check("ka_value", value, 32'h0000_000A);
    keys_down = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
